// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package seq_shift_add_mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   // Counter width needed to index WIDTH multiplier bits (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Start/busy/done handshake and operand/result bus of the multiplier.
interface seq_shift_add_mult_if #(parameter int unsigned WIDTH = 8);

   logic                 start;
   logic                 is_signed;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, is_signed, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, is_signed, a, b,
      output busy, done, product
   );

endinterface

// File: rtl/seq_shift_add_mult_cond_negate.sv
// Conditional two's-complement negation; purely combinational.
module cond_negate #(
   parameter int unsigned N = 8
) (
   input  logic         neg,
   input  logic [N-1:0] din,
   output logic [N-1:0] dout_c
);

   assign dout_c = neg ? (~din + N'(1)) : din;

endmodule

// File: rtl/seq_shift_add_mult.sv
// Multi-cycle shift-and-add multiplier: one multiplier bit per clock,
// unsigned or two's-complement operands selected per operation.
module seq_shift_add_mult
   import seq_shift_add_mult_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   seq_shift_add_mult_if.slave   bus
);

   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned CNT_W = cnt_width(WIDTH);

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   ma;
   logic [WIDTH-1:0]   mb;
   logic               neg;
   logic [PW-1:0]      acc;
   logic               busy_r;
   logic               done_r;
   logic [PW-1:0]      product_r;

   logic               accept_c;
   logic               step_c;
   logic               finish_c;
   logic               last_c;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [PW-1:0]      result;
   logic [PW-1:0]      partial;

   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.product = product_r;

   // Magnitudes of the operands and sign restoration of the accumulated result.
   cond_negate #(.N(WIDTH)) u_abs_a (
      .neg    (bus.is_signed & bus.a[WIDTH-1]),
      .din    (bus.a),
      .dout_c (abs_a)
   );

   cond_negate #(.N(WIDTH)) u_abs_b (
      .neg    (bus.is_signed & bus.b[WIDTH-1]),
      .din    (bus.b),
      .dout_c (abs_b)
   );

   cond_negate #(.N(PW)) u_result (
      .neg    (neg),
      .din    (acc),
      .dout_c (result)
   );

   assign last_c  = (cnt == CNT_W'(WIDTH - 1));
   assign partial = {{WIDTH{1'b0}}, ma} << cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      step_c     = 1'b0;
      finish_c   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               accept_c   = 1'b1;
               state_next = ST_CALC;
            end
         end
         ST_CALC: begin
            step_c = 1'b1;
            if (last_c) begin
               state_next = ST_FIN;
            end
         end
         ST_FIN: begin
            finish_c   = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Operand latch, accumulate-per-bit and result write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         ma        <= '0;
         mb        <= '0;
         neg       <= 1'b0;
         acc       <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         product_r <= '0;
      end else begin
         done_r <= 1'b0;
         if (accept_c) begin
            ma     <= abs_a;
            mb     <= abs_b;
            neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
         end
         if (step_c) begin
            if (mb[cnt]) begin
               acc <= acc + partial;
            end
            cnt <= cnt + CNT_W'(1);
         end
         if (finish_c) begin
            product_r <= result;
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench: WIDTH=3 and WIDTH=8 multipliers against an arithmetic model.
module tb_seq_shift_add_mult;

   logic clk;
   logic rst;
   int   vectors;
   int   fails;

   seq_shift_add_mult_if #(.WIDTH(3)) bus3 ();
   seq_shift_add_mult_if #(.WIDTH(8)) bus8 ();

   seq_shift_add_mult #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
   seq_shift_add_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Product as the mathematical value of the operands, truncated to 2*w bits.
   function automatic int model(input int w, input int x, input int y, input bit s);
      int xm;
      int ym;
      xm = x & ((1 << w) - 1);
      ym = y & ((1 << w) - 1);
      if (s) begin
         if (xm >= (1 << (w - 1))) xm = xm - (1 << w);
         if (ym >= (1 << (w - 1))) ym = ym - (1 << w);
      end
      return (xm * ym) & ((1 << (2 * w)) - 1);
   endfunction

   task automatic drive(input int w, input int x, input int y, input bit s, input bit st);
      if (w == 3) begin
         bus3.a = 3'(x); bus3.b = 3'(y); bus3.is_signed = s; bus3.start = st;
      end else begin
         bus8.a = 8'(x); bus8.b = 8'(y); bus8.is_signed = s; bus8.start = st;
      end
   endtask

   function automatic logic [31:0] rd_prod(input int w);
      return (w == 3) ? 32'(bus3.product) : 32'(bus8.product);
   endfunction

   function automatic logic rd_done(input int w);
      return (w == 3) ? bus3.done : bus8.done;
   endfunction

   function automatic logic rd_busy(input int w);
      return (w == 3) ? bus3.busy : bus8.busy;
   endfunction

   // One operation; inputs (including start) are scrambled while busy and must be ignored.
   task automatic run_op(input int w, input int x, input int y, input bit s, input string tag);
      int          n;
      logic [31:0] exp;
      logic [31:0] prev;
      exp  = 32'(model(w, x, y, s));
      prev = rd_prod(w);
      drive(w, x, y, s, 1'b1);
      @(posedge clk); #1;
      drive(w, int'($urandom), int'($urandom), 1'($urandom), 1'($urandom));
      check({tag, ".busy"}, 32'(rd_busy(w)), 32'd1);
      n = 0;
      while (!rd_done(w) && n < 40) begin
         check({tag, ".hold"}, rd_prod(w), prev);
         @(posedge clk); #1;
         n++;
         if (!rd_done(w)) drive(w, int'($urandom), int'($urandom), 1'($urandom), 1'($urandom));
      end
      drive(w, 0, 0, 1'b0, 1'b0);
      check({tag, ".latency"}, 32'(n), 32'(w + 1));
      check({tag, ".product"}, rd_prod(w), exp);
      check({tag, ".busy_low"}, 32'(rd_busy(w)), 32'd0);
      @(posedge clk); #1;
      check({tag, ".done_pulse"}, 32'(rd_done(w)), 32'd0);
      check({tag, ".product_held"}, rd_prod(w), exp);
   endtask

   initial begin
      int n;
      int seen_done;
      vectors = 0;
      fails   = 0;
      rst     = 1'b1;
      drive(3, 0, 0, 1'b0, 1'b0);
      drive(8, 0, 0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset.busy8", 32'(bus8.busy), 32'd0);
      check("reset.done8", 32'(bus8.done), 32'd0);
      check("reset.prod8", 32'(bus8.product), 32'd0);
      check("reset.prod3", 32'(bus3.product), 32'd0);

      run_op(3, 7, 7, 1'b0, "w3_7x7");
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            run_op(3, i, j, 1'b0, "w3_all");
         end
      end

      run_op(8, 'h80, 'h80, 1'b1, "s_min_min");
      run_op(8, -3, 5, 1'b1, "s_m3x5");
      run_op(8, 0, -1, 1'b1, "s_0xm1");
      run_op(8, 'hFF, 'hFF, 1'b0, "u_ffxff");
      for (int k = 0; k < 40; k++) begin
         run_op(8, int'($urandom), int'($urandom), 1'($urandom), "rand8");
      end

      // Back-to-back with start held high through done.
      drive(8, 5, 6, 1'b0, 1'b1);
      @(posedge clk); #1;
      bus8.a = 8'd3;
      bus8.b = 8'd4;
      n = 0;
      while (!bus8.done && n < 40) begin
         @(posedge clk); #1; n++;
      end
      check("b2b.first_latency", 32'(n), 32'd9);
      check("b2b.first_product", 32'(bus8.product), 32'd30);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!bus8.done && n < 40);
      bus8.start = 1'b0;
      check("b2b.gap", 32'(n), 32'd10);
      check("b2b.second_product", 32'(bus8.product), 32'd12);
      @(posedge clk); #1;
      check("b2b.idle", 32'(bus8.busy), 32'd0);

      // Reset sampled at iteration 3 aborts the operation without writing a result.
      drive(8, 'h55, 3, 1'b0, 1'b1);
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst.busy", 32'(bus8.busy), 32'd0);
      check("rst.done", 32'(bus8.done), 32'd0);
      check("rst.product", 32'(bus8.product), 32'd0);
      seen_done = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus8.done) seen_done++;
      end
      check("rst.no_done", 32'(seen_done), 32'd0);
      run_op(8, -128, 127, 1'b1, "post_rst");
      run_op(8, 200, 201, 1'b0, "post_rst_u");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
